// File: rtl/lifo_stack_ctrl.sv
// ---------------------------------------------------------------------------
// lifo_stack_ctrl
//
// Push/pop control and storage for a LIFO. Holds a DEPTH x WIDTH register-file
// stack and the stack pointer (which is also the occupancy count). It also
// arbitrates push/pop requests and reports registered pop data and status.
//
// Ports:
//   CLK        - single clock, all state changes on the rising edge
//   Reset      - synchronous active-high reset
//   push       - write din onto the top of the stack
//   pop        - remove the top entry and present it on dout
//   din        - push data (WIDTH bits)
//   dout       - registered pop data; holds between pops
//   dout_valid - one-cycle pulse: dout was updated by the preceding edge
//   count      - occupancy, 0..DEPTH (AW+1 bits)
//   full       - count == DEPTH
//   empty      - count == 0
//   ovf        - one-cycle pulse: a push was rejected (stack full)
//   udf        - one-cycle pulse: a pop was rejected (stack empty)
// ---------------------------------------------------------------------------
module lifo_stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;

  assign full  = (sp_q == DEPTH_C);
  assign empty = (sp_q == '0);

  // Address of the current top entry. When sp == DEPTH the low AW bits are
  // zero and the subtraction wraps to DEPTH-1, which is exactly the top slot.
  assign top_addr = sp_q[AW-1:0] - 1'b1;

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    we     = 1'b0;
    waddr  = sp_q[AW-1:0];
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          we   = 1'b1;
          sp_d = sp_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          dout_d = mem[top_addr];
          sp_d   = sp_q - 1'b1;
          dv_d   = 1'b1;
        end else begin
          udf_d = 1'b1;
        end
      end
      2'b11: begin
        dv_d = 1'b1;
        if (!empty) begin
          // Swap: old top goes out, new word replaces it in place.
          dout_d = mem[top_addr];
          we     = 1'b1;
          waddr  = top_addr;
        end else begin
          // Nothing to pop: the pushed word passes straight through.
          dout_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sp_q   <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage is not reset; entries at or above sp are never read.
  always_ff @(posedge CLK) begin
    if (!Reset && we) begin
      mem[waddr] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign count      = sp_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack_ctrl
//
// Self-checking bench for lifo_stack_ctrl. A queue-based reference model
// tracks the stack contents and expected pulse/data outputs; directed
// scenario tasks and a randomized run compare the DUT against it.
// ---------------------------------------------------------------------------
module tb_lifo_stack_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dv;
  logic             m_ovf;
  logic             m_udf;

  lifo_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK        (clk),
    .Reset      (rst),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
    .udf        (udf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model, and return 1 time unit
  // after the rising edge so outputs can be sampled.
  task automatic cyc(input logic p, input logic o, input logic [WIDTH-1:0] d,
                     input logic r);
    push = p;
    pop  = o;
    din  = d;
    rst  = r;
    if (r) begin
      q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      m_dv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      if (p && o) begin
        m_dv = 1'b1;
        if (q.size() == 0) begin
          m_dout = d;
        end else begin
          m_dout = q[q.size()-1];
          q[q.size()-1] = d;
        end
      end else if (p) begin
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(d);
      end else if (o) begin
        if (q.size() == 0) m_udf = 1'b1;
        else begin
          m_dout = q.pop_back();
          m_dv   = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if ({dout_valid, ovf, udf} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {dout_valid, ovf, udf}); end
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'hA0 + i), 0);
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL fill5_count got %0d exp 5", count); end
    cyc(0, 0, 8'h00, 1);
    checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL midreset got count=%0d empty=%b exp 0/1", count, empty); end
    // Stale entries must not reappear after reset.
    cyc(0, 1, 8'h00, 0);
    checks++; if (udf !== 1'b1 || dout_valid !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL post_reset_pop got udf=%b dv=%b dout=%h exp 1/0/00", udf, dout_valid, dout); end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_lifo_order;
    logic [WIDTH-1:0] exp_v;
    cyc(0, 0, 8'h00, 0);
    cyc(1, 0, 8'h11, 0);
    cyc(1, 0, 8'h22, 0);
    cyc(1, 0, 8'h33, 0);
    for (int i = 0; i < 3; i++) begin
      exp_v = 8'(8'h33 - 8'h11 * i);
      cyc(0, 1, 8'h00, 0);
      checks++; if (dout !== exp_v || dout_valid !== 1'b1) begin errors++; $display("FAIL lifo_pop%0d got dout=%h dv=%b exp %h/1", i, dout, dout_valid, exp_v); end
      checks++; if (dout !== m_dout) begin errors++; $display("FAIL lifo_model%0d got %h exp %h", i, dout, m_dout); end
    end
    checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL lifo_drained got count=%0d empty=%b exp 0/1", count, empty); end
    $display("test_lifo_order done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full_ovf;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 8'(i), 0);
      checks++; if (full !== (i == DEPTH-1)) begin errors++; $display("FAIL fill_full%0d got %b exp %b", i, full, (i == DEPTH-1)); end
    end
    checks++; if (count !== 6'd32 || full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL full_state got count=%0d full=%b empty=%b exp 32/1/0", count, full, empty); end
    cyc(1, 0, 8'hAA, 0);
    checks++; if (ovf !== 1'b1 || count !== 6'd32) begin errors++; $display("FAIL ovf_pulse got ovf=%b count=%0d exp 1/32", ovf, count); end
    cyc(0, 0, 8'h00, 0);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_width got %b exp 0", ovf); end
    cyc(0, 1, 8'h00, 0);
    checks++; if (dout !== 8'h1F || dout_valid !== 1'b1 || count !== 6'd31) begin errors++; $display("FAIL full_pop got dout=%h dv=%b count=%0d exp 1f/1/31", dout, dout_valid, count); end
    // Swap while full: no ovf, count stays full.
    cyc(1, 0, 8'hC3, 0);
    cyc(1, 1, 8'hD4, 0);
    checks++; if (dout !== 8'hC3 || ovf !== 1'b0 || count !== 6'd32) begin errors++; $display("FAIL full_swap got dout=%h ovf=%b count=%0d exp c3/0/32", dout, ovf, count); end
    cyc(0, 0, 8'h00, 1);
    $display("test_full_ovf done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_underflow;
    cyc(1, 0, 8'h42, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    checks++; if (udf !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL udf_pulse got udf=%b dv=%b exp 1/0", udf, dout_valid); end
    checks++; if (dout !== 8'h42 || count !== 6'd0) begin errors++; $display("FAIL udf_hold got dout=%h count=%0d exp 42/0", dout, count); end
    cyc(0, 0, 8'h00, 0);
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_width got %b exp 0", udf); end
    $display("test_underflow done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_push_pop;
    cyc(1, 0, 8'h01, 0);
    cyc(1, 0, 8'h02, 0);
    cyc(1, 1, 8'h99, 0);
    checks++; if (dout !== 8'h02 || count !== 6'd2 || dout_valid !== 1'b1) begin errors++; $display("FAIL swap got dout=%h count=%0d dv=%b exp 02/2/1", dout, count, dout_valid); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL swap_err got ovf=%b udf=%b exp 0/0", ovf, udf); end
    cyc(0, 1, 8'h00, 0);
    checks++; if (dout !== 8'h99) begin errors++; $display("FAIL swap_follow got %h exp 99", dout); end
    cyc(0, 1, 8'h00, 0);
    checks++; if (dout !== 8'h01 || empty !== 1'b1) begin errors++; $display("FAIL swap_bottom got dout=%h empty=%b exp 01/1", dout, empty); end
    $display("test_push_pop done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_passthrough;
    cyc(1, 1, 8'h5C, 0);
    checks++; if (dout !== 8'h5C || dout_valid !== 1'b1) begin errors++; $display("FAIL passthru got dout=%h dv=%b exp 5c/1", dout, dout_valid); end
    checks++; if (count !== 6'd0 || udf !== 1'b0) begin errors++; $display("FAIL passthru_state got count=%0d udf=%b exp 0/0", count, udf); end
    cyc(1, 0, 8'h77, 1);
    checks++; if (count !== 6'd0 || ovf !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL reset_push got count=%0d ovf=%b dout=%h exp 0/0/00", count, ovf, dout); end
    $display("test_passthrough done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random;
    int pp, po;
    logic p, o, r;
    for (int n = 0; n < 600; n++) begin
      // Bias phases toward filling, draining and mixed traffic.
      case ((n / 100) % 3)
        0: begin pp = 80; po = 20; end
        1: begin pp = 20; po = 80; end
        default: begin pp = 50; po = 50; end
      endcase
      p = ($urandom_range(99) < pp);
      o = ($urandom_range(99) < po);
      r = ($urandom_range(199) == 0);
      cyc(p, o, 8'($urandom), r);
      checks++;
      if (count !== 6'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        errors++;
        $display("FAIL rnd_state cyc %0d got count=%0d full=%b empty=%b exp count=%0d", n, count, full, empty, q.size());
      end
      checks++;
      if (dout !== m_dout || dout_valid !== m_dv || ovf !== m_ovf || udf !== m_udf) begin
        errors++;
        $display("FAIL rnd_out cyc %0d got dout=%h dv=%b ovf=%b udf=%b exp %h/%b/%b/%b", n, dout, dout_valid, ovf, udf, m_dout, m_dv, m_ovf, m_udf);
      end
    end
    $display("test_random done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    push = 1'b0;
    pop  = 1'b0;
    din  = '0;
    rst  = 1'b1;
    m_dout = '0;
    m_dv = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    test_reset();
    test_lifo_order();
    test_full_ovf();
    test_underflow();
    test_push_pop();
    test_passthrough();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
